// File: rtl/por_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : por_pkg
//  Description : Shared definitions for the power-on-reset sequencer: FSM
//                state encoding, default parameter values, test-mode
//                timings and a small width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package por_pkg;

  // Default parameter values for por_seq
  localparam int NCH_DEF    = 4;
  localparam int ST_CNT_DEF = 37;
  localparam int STW_DEF    = 6;
  localparam int PW_DEF     = 11;
  localparam int DLYW_DEF   = 8;

  // Shortened timings used when force_short_oneshot is set
  localparam int SHORT_ST  = 4;
  localparam int SHORT_POR = 8;
  localparam int SHORT_DLY = 1;

  typedef enum logic [2:0] {
    S_RSYNC   = 3'd0,
    S_STARTUP = 3'd1,
    S_POR     = 3'd2,
    S_SEQ     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Largest of three widths; sizes the single shared phase counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/por_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : por_sync2
//  Description : Two-flop synchroniser with asynchronous active-low clear.
//                Used for reset release and for the brownout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module por_sync2 (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of d; both stages clear to 0 while clr_n is low
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/por_seq.sv
`default_nettype none
// ============================================================================
//  Module      : por_seq
//  Description : Power-on-reset sequencer. After supply-good is released it
//                runs a startup one-shot, emits a POR pulse, then releases
//                NCH reset channels one after another with programmable
//                gaps. A synchronised brownout restarts the whole sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module por_seq
  import por_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int ST_CNT = ST_CNT_DEF,
  parameter int STW    = STW_DEF,
  parameter int PW     = PW_DEF,
  parameter int DLYW   = DLYW_DEF
) (
  input  logic                osc_ck,
  input  logic                pwup_filt,
  input  logic                bod_n,
  input  logic                force_short_oneshot,
  input  logic                force_ena_rc_osc,
  input  logic                force_dis_rc_osc,
  input  logic [PW-1:0]       por_len,
  input  logic [NCH*DLYW-1:0] dly_cfg,
  output logic                osc_ena,
  output logic                por_unbuf,
  output logic [NCH-1:0]      rst_n,
  output logic                por_done,
  output logic                bod_seen,
  output logic [2:0]          state
);

  localparam int CW = max3(STW, PW, DLYW);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                rel;       // synchronised reset release
  logic                bod_q;     // synchronised bod_n
  logic                bod_low;
  state_t              cur;       // registered FSM state
  state_t              eff;       // architectural state
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       lim;
  logic                tc;
  logic [IW-1:0]       idx;
  logic [PW-1:0]       por_sh;
  logic [NCH*DLYW-1:0] dly_sh;
  logic [DLYW-1:0]     dly_cur;

  por_sync2 u_rel_sync (
    .clk   (osc_ck),
    .clr_n (pwup_filt),
    .d     (1'b1),
    .q     (rel)
  );

  por_sync2 u_bod_sync (
    .clk   (osc_ck),
    .clr_n (pwup_filt),
    .d     (bod_n),
    .q     (bod_q)
  );

  assign bod_low = ~bod_q;

  // The second synchroniser stage rising is itself the STARTUP entry edge:
  // the registered state still reads RSYNC for that one cycle, so it is
  // presented as STARTUP and the FSM runs the STARTUP branch with cnt = 0.
  assign eff   = (cur == S_RSYNC && rel) ? S_STARTUP : cur;
  assign state = eff;

  assign osc_ena = force_ena_rc_osc |
                   (~force_dis_rc_osc & pwup_filt & (eff != S_DONE));

  assign dly_cur = dly_sh[idx*DLYW +: DLYW];

  // Phase length of the current state; zero lengths are treated as one cycle
  always_comb begin
    lim = CW'(1);
    case (eff)
      S_STARTUP: lim = force_short_oneshot ? CW'(SHORT_ST) : CW'(ST_CNT);
      S_POR:     lim = force_short_oneshot ? CW'(SHORT_POR) :
                       ((por_sh == '0) ? CW'(1) : CW'(por_sh));
      S_SEQ:     lim = (force_short_oneshot || dly_cur == '0) ?
                       CW'(SHORT_DLY) : CW'(dly_cur);
      default:   lim = CW'(1);
    endcase
  end

  assign tc = (cnt == lim - CW'(1));

  // Sequencer FSM; brownout is checked first so it wins over any terminal count
  always_ff @(posedge osc_ck or negedge pwup_filt) begin
    if (!pwup_filt) begin
      cur       <= S_RSYNC;
      cnt       <= '0;
      idx       <= '0;
      rst_n     <= '0;
      por_unbuf <= 1'b0;
      por_done  <= 1'b0;
      bod_seen  <= 1'b0;
      por_sh    <= '0;
      dly_sh    <= '0;
    end else if (eff != S_RSYNC && bod_low) begin
      cur       <= S_STARTUP;
      cnt       <= '0;
      idx       <= '0;
      rst_n     <= '0;
      por_unbuf <= 1'b0;
      por_done  <= 1'b0;
      bod_seen  <= 1'b1;
      // Capture only on the edge that enters STARTUP, not while held there
      if (eff != S_STARTUP) begin
        por_sh <= por_len;
        dly_sh <= dly_cfg;
      end
    end else begin
      case (eff)
        S_RSYNC: begin
          // Last capture happens on the STARTUP entry edge
          por_sh <= por_len;
          dly_sh <= dly_cfg;
        end
        S_STARTUP: begin
          cur <= S_STARTUP;
          if (tc) begin
            cur       <= S_POR;
            cnt       <= '0;
            por_unbuf <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_POR: begin
          if (tc) begin
            cur       <= S_SEQ;
            cnt       <= '0;
            por_unbuf <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SEQ: begin
          if (tc) begin
            rst_n[idx] <= 1'b1;
            cnt        <= '0;
            if (idx == IW'(NCH - 1)) begin
              cur      <= S_DONE;
              por_done <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cur <= S_DONE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_por_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_por_seq
//  Description : Self-checking bench for por_seq. Cycle numbers are counted
//                in osc_ck rising edges after pwup_filt is released; each
//                table row gives the expected outputs just after that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_por_seq;

  logic        osc_ck = 1'b0;
  logic        pwup_filt;
  logic        bod_n;
  logic        fso;
  logic        fena;
  logic        fdis;
  logic [10:0] por_len;
  logic [31:0] dly_cfg;
  logic        osc_ena;
  logic        por_unbuf;
  logic [3:0]  rst_n;
  logic        por_done;
  logic        bod_seen;
  logic [2:0]  state;

  por_seq #(.NCH(4), .ST_CNT(37), .STW(6), .PW(11), .DLYW(8)) dut (
    .osc_ck              (osc_ck),
    .pwup_filt           (pwup_filt),
    .bod_n               (bod_n),
    .force_short_oneshot (fso),
    .force_ena_rc_osc    (fena),
    .force_dis_rc_osc    (fdis),
    .por_len             (por_len),
    .dly_cfg             (dly_cfg),
    .osc_ena             (osc_ena),
    .por_unbuf           (por_unbuf),
    .rst_n               (rst_n),
    .por_done            (por_done),
    .bod_seen            (bod_seen),
    .state               (state)
  );

  always #5 osc_ck = ~osc_ck;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       por;
    logic [3:0] rn;
    logic       done;
    logic       bs;
    logic       osc;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic logic [10:0] pk(input logic [2:0] s, input logic p, input logic [3:0] r,
                                     input logic d, input logic b, input logic o);
    return {s, p, r, d, b, o};
  endfunction

  function automatic logic [10:0] snap();
    return {state, por_unbuf, rst_n, por_done, bod_seen, osc_ena};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int c, input logic [2:0] s, input logic p, input logic [3:0] r,
                     input logic d, input logic b, input logic o);
    vec_t v;
    v.cyc = c; v.st = s; v.por = p; v.rn = r; v.done = d; v.bs = b; v.osc = o;
    tbl.push_back(v);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge osc_ck);
      #1;
      cyc++;
    end
  endtask

  task automatic run_table(input string name);
    foreach (tbl[k]) begin
      step_to(tbl[k].cyc);
      check($sformatf("%s@%0d", name, tbl[k].cyc), 32'(snap()),
            32'(pk(tbl[k].st, tbl[k].por, tbl[k].rn, tbl[k].done, tbl[k].bs, tbl[k].osc)));
    end
    tbl.delete();
  endtask

  task automatic assert_reset();
    @(negedge osc_ck);
    pwup_filt = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge osc_ck);
    pwup_filt = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pwup_filt = 1'b1;
    bod_n     = 1'b1;
    fso       = 1'b0;
    fena      = 1'b0;
    fdis      = 1'b0;
    por_len   = 11'd100;
    dly_cfg   = {8'd4, 8'd3, 8'd2, 8'd1};
    #2 pwup_filt = 1'b0;
    repeat (3) @(negedge osc_ck);
    check("reset_state", 32'(snap()), 32'(pk(3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0)));

    // Defaults: por_len=100, delays 1,2,3,4
    release_reset();
    add(1,   3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(2,   3'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(38,  3'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(39,  3'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(138, 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(139, 3'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(140, 3'd3, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(141, 3'd3, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(142, 3'd3, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1);
    add(144, 3'd3, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1);
    add(145, 3'd3, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
    add(148, 3'd3, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
    add(149, 3'd4, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_table("dflt");

    // Shortened test-mode timings
    assert_reset();
    check("reset_mid_done", 32'(snap()), 32'(pk(3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0)));
    fso = 1'b1;
    release_reset();
    add(1,  3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(2,  3'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(5,  3'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(6,  3'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(13, 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(14, 3'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(15, 3'd3, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(16, 3'd3, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1);
    add(17, 3'd3, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
    add(18, 3'd4, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_table("short");

    // Brownout in SEQ after channel 1 release; brownout coincides with ch2 terminal count
    assert_reset();
    fso = 1'b0;
    release_reset();
    add(39,  3'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(142, 3'd3, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1);
    run_table("bod_pre");
    bod_n = 1'b0;
    step_to(144);
    check("bod_sync_delay", 32'(snap()), 32'(pk(3'd3, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1)));
    step_to(145);
    bod_n = 1'b1;
    check("bod_hit", 32'(snap()), 32'(pk(3'd1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1)));
    add(147, 3'd1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(183, 3'd1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(184, 3'd2, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(283, 3'd2, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(284, 3'd3, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(285, 3'd3, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1);
    add(293, 3'd3, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b1);
    add(294, 3'd4, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    run_table("bod_rerun");

    // Second brownout from DONE, then pwup_filt dropped mid-POR
    bod_n = 1'b0;
    step_to(cyc + 3);
    bod_n = 1'b1;
    check("bod_from_done", 32'(snap()), 32'(pk(3'd1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1)));
    for (int n = 0; n < 300 && state != 3'd2; n++) step_to(cyc + 1);
    check("bod2_por_reached", 32'(state), 32'd2);
    step_to(cyc + 10);
    check("mid_por", 32'(snap()), 32'(pk(3'd2, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1)));
    #2 pwup_filt = 1'b0;
    #1;
    check("por_abort", 32'(snap()), 32'(pk(3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0)));

    // Zero lengths; por_len and dly_cfg changes during POR must be ignored
    por_len = 11'd0;
    dly_cfg = 32'd0;
    release_reset();
    add(38, 3'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(39, 3'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_table("zero_a");
    por_len = 11'd5;
    dly_cfg = {4{8'd9}};
    add(40, 3'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(41, 3'd3, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(42, 3'd3, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1);
    add(43, 3'd3, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
    add(44, 3'd4, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_table("zero_b");

    // Oscillator enable overrides
    fena = 1'b1;
    #1;
    check("osc_force_ena_done", 32'(osc_ena), 32'd1);
    fena = 1'b0;
    #1;
    check("osc_done_release", 32'(osc_ena), 32'd0);
    assert_reset();
    release_reset();
    step_to(10);
    fdis = 1'b1;
    #1;
    check("osc_dis_state", 32'(state), 32'd1);
    check("osc_force_dis", 32'(osc_ena), 32'd0);
    fena = 1'b1;
    #1;
    check("osc_ena_over_dis", 32'(osc_ena), 32'd1);
    fena = 1'b0;
    fdis = 1'b0;
    #1;
    check("osc_startup", 32'(osc_ena), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
